// File: rtl/key_event_fifo.sv
// Debounced key-event queue: filters the scanner's code/valid pair, turns stable
// press/release transitions into event words and buffers them for a register-bus reader.
module key_event_fifo #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  addrIn,
  input  logic [7:0]  addrOut,
  input  logic [3:0]  sizeDecode,
  input  logic [31:0] dataIn,
  output logic [31:0] dataOut,
  input  logic [3:0]  keyCode,
  input  logic        keyEnable,
  output logic        irq
);

  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam logic [15:0] CNT_MAX   = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0] LAST_PTR  = (AW + 1)'(FIFO_DEPTH - 1);
  localparam logic [AW:0] ONE       = (AW + 1)'(1);

  // Key path state: {enable, code} packed as 5 bits throughout.
  logic [4:0]  s1;
  logic [4:0]  cand;
  logic [4:0]  stable;
  logic [15:0] cnt;
  logic        accept;

  // Event produced on acceptance.
  logic        ev_valid;
  logic [4:0]  ev_word;

  // Bus decode.
  logic        wr_lane0;
  logic        pop_req;
  logic        flush;
  logic        clr_ovf;

  // FIFO state.
  logic [4:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] count;
  logic        ovf;
  logic        empty;
  logic        full;
  logic        do_pop;
  logic        do_push;
  logic        overflow;

  logic [31:0] rd_data;
  logic        unused_bits;

  assign unused_bits = ^{dataIn[31:2], sizeDecode[3:1]};

  function automatic logic [AW:0] ptr_inc(input logic [AW:0] p);
    return (p == LAST_PTR) ? '0 : p + ONE;
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1     <= '0;
      cand   <= '0;
      cnt    <= '0;
      stable <= '0;
    end else begin
      s1 <= {keyEnable, keyCode};
      if (s1 != cand) begin
        cand <= s1;
        cnt  <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 16'd1;
      end
      if (accept) begin
        stable <= cand;
      end
    end
  end

  assign accept = (s1 == cand) && (cnt == CNT_MAX) && (cand != stable);

  // A code change while held reports only the new press; a silent 0->0 change yields nothing.
  always_comb begin
    ev_valid = 1'b0;
    ev_word  = '0;
    if (accept) begin
      if (cand[4]) begin
        ev_valid = 1'b1;
        ev_word  = {1'b1, cand[3:0]};
      end else if (stable[4]) begin
        ev_valid = 1'b1;
        ev_word  = {1'b0, stable[3:0]};
      end
    end
  end

  assign wr_lane0 = sizeDecode[0];
  assign pop_req  = wr_lane0 && (addrIn == 8'd0) && dataIn[0];
  assign flush    = wr_lane0 && (addrIn == 8'd1) && dataIn[0];
  assign clr_ovf  = wr_lane0 && (addrIn == 8'd1) && dataIn[1];

  assign empty    = (count == '0);
  assign full     = (count == DEPTH_CNT);
  assign do_pop   = pop_req && !empty && !flush;
  assign do_push  = ev_valid && !flush && (!full || do_pop);
  assign overflow = ev_valid && !flush && full && !do_pop;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only entries between the pointers are ever observed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= ev_word;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf <= 1'b0;
    end else if (overflow) begin
      ovf <= 1'b1;
    end else if (clr_ovf) begin
      ovf <= 1'b0;
    end
  end

  always_comb begin
    rd_data = '0;
    case (addrOut)
      8'd0: rd_data = empty ? 32'hFFFF_FFFF : {27'd0, mem[rd_ptr[AW-1:0]]};
      8'd1: begin
        rd_data[4:0]   = 5'(count);
        rd_data[8]     = empty;
        rd_data[9]     = full;
        rd_data[10]    = ovf;
        rd_data[20:16] = stable;
      end
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dataOut <= '0;
      irq     <= 1'b0;
    end else begin
      dataOut <= rd_data;
      irq     <= !empty;
    end
  end

endmodule

// File: tb/tb_key_event_fifo.sv
// Randomized bench for key_event_fifo: a run-length/queue model predicts dataOut and irq
// every cycle, and directed scenarios pin the model with hand-computed register values.
module tb_key_event_fifo;

  localparam int DC    = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [7:0]  addrIn = '0;
  logic [7:0]  addrOut = '0;
  logic [3:0]  sizeDecode = '0;
  logic [31:0] dataIn = '0;
  logic [31:0] dataOut;
  logic [3:0]  keyCode = '0;
  logic        keyEnable = 1'b0;
  logic        irq;

  int checks = 0;
  int passes = 0;

  key_event_fifo #(.DEBOUNCE_CYCLES(DC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .addrIn(addrIn), .addrOut(addrOut),
    .sizeDecode(sizeDecode), .dataIn(dataIn), .dataOut(dataOut),
    .keyCode(keyCode), .keyEnable(keyEnable), .irq(irq)
  );

  always #5 clk = ~clk;

  // Model: the input is accepted once the same sample has been seen DC+1 captures in a row.
  logic [4:0]  q[$];
  logic        m_ovf = 1'b0;
  logic [4:0]  m_stable = '0;
  logic [4:0]  m_s1 = '0;
  int          m_run = 2;
  logic [31:0] exp_dout = '0;
  logic        exp_irq = 1'b0;
  bit          model_on = 0;
  bit          ev, popped, ovf_set, fl, cl, pp;
  logic [4:0]  ew, nw;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
  endtask

  function automatic logic [31:0] model_read(input logic [7:0] a);
    logic [31:0] r;
    r = '0;
    if (a == 8'd0) begin
      r = (q.size() == 0) ? 32'hFFFF_FFFF : {27'd0, q[0]};
    end else if (a == 8'd1) begin
      r[4:0]   = 5'(q.size());
      r[8]     = (q.size() == 0);
      r[9]     = (q.size() == DEPTH);
      r[10]    = m_ovf;
      r[20:16] = m_stable;
    end
    return r;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q.delete();
      m_ovf = 1'b0; m_stable = '0; m_s1 = '0; m_run = 2;
      exp_dout = '0; exp_irq = 1'b0;
    end else begin
      exp_dout = model_read(addrOut);
      exp_irq  = (q.size() != 0);
      ev = 0; ew = '0;
      if (m_run >= DC + 1 && m_s1 != m_stable) begin
        if (m_s1[4]) begin ev = 1; ew = {1'b1, m_s1[3:0]}; end
        else if (m_stable[4]) begin ev = 1; ew = {1'b0, m_stable[3:0]}; end
        m_stable = m_s1;
      end
      fl = sizeDecode[0] && addrIn == 8'd1 && dataIn[0];
      cl = sizeDecode[0] && addrIn == 8'd1 && dataIn[1];
      pp = sizeDecode[0] && addrIn == 8'd0 && dataIn[0];
      ovf_set = 0; popped = 0;
      if (fl) begin
        q.delete();
      end else begin
        if (pp && q.size() > 0) begin void'(q.pop_front()); popped = 1; end
        if (ev) begin
          if (q.size() < DEPTH) q.push_back(ew);
          else ovf_set = 1;
        end
      end
      if (ovf_set) m_ovf = 1'b1;
      else if (cl) m_ovf = 1'b0;
      nw = {keyEnable, keyCode};
      if (nw == m_s1) m_run = (m_run < 1000) ? m_run + 1 : m_run;
      else m_run = 1;
      m_s1 = nw;
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      check("dataOut", dataOut, exp_dout);
      check("irq", {31'd0, irq}, {31'd0, exp_irq});
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    #2 rstn = 1'b0;
    keyEnable = 1'b0; keyCode = '0; sizeDecode = '0; dataIn = '0; addrIn = '0; addrOut = '0;
    model_on = 1;
    @(negedge clk);
    @(negedge clk);
    #2 rstn = 1'b1;
  endtask

  task automatic set_key(input logic en, input logic [3:0] code);
    @(negedge clk);
    keyEnable = en;
    keyCode = code;
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    addrIn = a; sizeDecode = 4'h1; dataIn = d;
    @(negedge clk);
    sizeDecode = '0; dataIn = '0;
  endtask

  task automatic read_check(input logic [7:0] a, input logic [31:0] req, input string name);
    @(negedge clk);
    addrOut = a;
    @(posedge clk);
    #1 check(name, dataOut, req);
  endtask

  task automatic applyStimulus();
    int hold_left;
    // Reset values
    apply_reset();
    read_check(8'd0, 32'hFFFF_FFFF, "data_empty");
    read_check(8'd1, 32'h0000_0100, "status_reset");
    check("irq_reset", {31'd0, irq}, 32'd0);

    // Single press, latency and pop
    @(negedge clk);
    keyEnable = 1'b1; keyCode = 4'h5; addrOut = 8'd1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #1 check("status_before_accept", dataOut, 32'h0000_0100);
    check("irq_before", {31'd0, irq}, 32'd0);
    @(posedge clk);
    #1 check("status_after_accept", dataOut, 32'h0015_0001);
    check("irq_rise", {31'd0, irq}, 32'd1);
    read_check(8'd0, 32'h0000_0015, "data_press5");
    @(negedge clk);
    addrIn = 8'd0; sizeDecode = 4'h1; dataIn = 32'd1;
    @(posedge clk);
    #1 check("irq_pop_edge", {31'd0, irq}, 32'd1);
    @(negedge clk);
    sizeDecode = '0; dataIn = '0;
    @(posedge clk);
    #1 check("irq_after_pop", {31'd0, irq}, 32'd0);
    read_check(8'd1, 32'h0015_0100, "status_after_pop");

    // Bouncing input never produces an event
    apply_reset();
    for (int i = 0; i < 14; i++) begin
      set_key(i[0], 4'h0);
      hold(2);
    end
    set_key(1'b0, 4'h0);
    hold(10);
    read_check(8'd1, 32'h0000_0100, "status_bounce");

    // Fill the FIFO, then overflow
    set_key(1'b1, 4'h5); hold(10);
    set_key(1'b0, 4'h5); hold(10);
    set_key(1'b1, 4'hA); hold(10);
    set_key(1'b0, 4'hA); hold(10);
    read_check(8'd1, 32'h000A_0204, "status_full");
    read_check(8'd0, 32'h0000_0015, "head_full");
    set_key(1'b1, 4'h3); hold(10);
    read_check(8'd1, 32'h0013_0604, "status_ovf");

    // Pop in the cycle an event arrives while full
    bus_write(8'd1, 32'd2);
    read_check(8'd1, 32'h0013_0204, "status_ovf_cleared");
    set_key(1'b0, 4'h3);
    hold(4);
    @(negedge clk);
    addrIn = 8'd0; sizeDecode = 4'h1; dataIn = 32'd1;
    @(negedge clk);
    sizeDecode = '0; dataIn = '0;
    hold(3);
    read_check(8'd1, 32'h0003_0204, "status_pop_push_full");
    read_check(8'd0, 32'h0000_0005, "head_after_pop");
    bus_write(8'd0, 32'd1);
    bus_write(8'd0, 32'd1);
    bus_write(8'd0, 32'd1);
    read_check(8'd0, 32'h0000_0003, "tail_entry");

    // Flush + clear in the cycle an event arrives
    set_key(1'b1, 4'h7);
    hold(4);
    @(negedge clk);
    addrIn = 8'd1; sizeDecode = 4'h1; dataIn = 32'd3;
    @(posedge clk);
    #1 check("irq_flush_edge", {31'd0, irq}, 32'd1);
    @(negedge clk);
    sizeDecode = '0; dataIn = '0;
    @(posedge clk);
    #1 check("irq_after_flush", {31'd0, irq}, 32'd0);
    read_check(8'd1, 32'h0017_0100, "status_flush");

    // Randomized traffic against the model
    hold_left = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (hold_left == 0) begin
        keyEnable = ($urandom_range(0, 2) != 0);
        keyCode   = 4'($urandom_range(0, 15));
        hold_left = $urandom_range(1, 10);
      end else begin
        hold_left--;
      end
      addrOut = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 99) < 12) begin
        addrIn     = 8'($urandom_range(0, 2));
        sizeDecode = 4'($urandom_range(0, 15));
        dataIn     = $urandom;
      end else begin
        sizeDecode = '0;
      end
      if ($urandom_range(0, 999) == 0) begin
        #2 rstn = 1'b0;
        @(negedge clk);
        #2 rstn = 1'b1;
      end
    end
    sizeDecode = '0;
    hold(3);
  endtask

  initial begin
    applyStimulus();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/key_event_fifo.md
# key_event_fifo

Debounced key-event queue sitting directly downstream of the 4x4 matrix keyboard scanner. It takes the scanner's raw encoded key code and key-valid flag, debounces them, turns stable press and release transitions into events, and buffers those events in a small FIFO. Software drains the FIFO through the standard peripheral register bus. An interrupt-level output is high whenever events are pending.

## Interface
- DEBOUNCE_CYCLES, 50000: consecutive identical samples required before an input value is accepted; legal range 2..65535.
- FIFO_DEPTH, 8: number of event entries; must be a power of two, 2..16.
- clk  in  1  system clock; everything is sampled on its rising edge.
- rstn  in  1  reset, asynchronous assert, active-low.
- addrIn  in  8  write word address.
- addrOut  in  8  read word address.
- sizeDecode  in  4  byte-lane write enables; all-zero means no write.
- dataIn  in  32  write data.
- dataOut  out  32  registered read data.
- keyCode  in  4  raw encoded key from the scanner, asynchronous to key bounce.
- keyEnable  in  1  raw key-valid flag from the scanner.
- irq  out  1  registered; high while the FIFO is non-empty.

## Operation
**Input synchronisation**
- {keyEnable, keyCode} is registered into s1 every cycle.

**Debounce**
- cand (5 bits) and cnt (16 bits) track the incoming value.
- If s1 != cand: cand <= s1 and cnt <= 0.
- Otherwise cnt increments, saturating at DEBOUNCE_CYCLES-1.
- Accept condition: s1 == cand, cnt == DEBOUNCE_CYCLES-1, and cand != stable. On accept: stable <= cand and one event is generated in the same cycle.

**Event generation (from the old stable value to cand)**
- Enable 0->1: press event with code cand.code.
- Enable 1->0: release event with code old stable.code.
- Enable 1->1 with a different code: press event for the new code only; no release is generated.
- Enable 0->0 with a code change: stable updates silently, no event.

**Event word**
- [3:0] = code, [4] = 1 for press / 0 for release, [31:5] = 0.

**FIFO**
- Write pointer, read pointer and count are (log2 FIFO_DEPTH + 1) bits; pointers wrap modulo FIFO_DEPTH.
- Push on event. If the FIFO is full and no pop happens in the same cycle, the event is dropped and the sticky ovf flag is set.
- Push and pop in the same cycle both take effect and count is unchanged, including when full (no overflow) and when empty (a pop on empty is ignored and the push succeeds).
- Flush clears both pointers and count in one cycle and has priority over push and pop in that cycle. An event generated in the flush cycle is discarded and does not set ovf.

**Register map (word address)**
- 0 DATA, read: the head entry, or 32'hFFFF_FFFF when empty. This matches the scanner's "no key" value.
- 0 DATA, write: if sizeDecode[0] and dataIn[0] are both set, pop the head.
- 1 STATUS, read: [4:0] count, [8] empty, [9] full, [10] ovf, [19:16] stable.code, [20] stable.enable; all other bits 0.
- 1 STATUS, write: with sizeDecode[0] set, dataIn[0] = 1 flushes and dataIn[1] = 1 clears ovf. Both may be set together.
- Other addresses read 0, and writes to them are ignored. Only byte lane 0 is decoded.
- Clearing ovf in the same cycle as a new overflow leaves ovf = 1.

**Reset values (rstn low)**
- dataOut = 0, irq = 0.
- s1, cand, stable = 0; cnt = 0.
- Pointers and count = 0, ovf = 0. FIFO storage contents are don't-care.
- Reset asserted mid-debounce or mid-access abandons all state immediately.

## Timing
- Read: dataOut updates on the edge after addrOut is presented, giving 1-cycle latency. It reflects the FIFO state before any pop performed on that same edge.
- Pop, flush and clear take effect on the edge at which the write is sampled. A read of DATA issued on the following cycle sees the new head.
- Debounce latency: a new input value first captured into s1 at edge E, and held, gives stable update and push at edge E+DEBOUNCE_CYCLES+1. irq rises at edge E+DEBOUNCE_CYCLES+2.
- Any change of s1 before acceptance restarts the count from the next edge.
- irq falls on the edge after count reaches 0 through a pop or flush.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4 and FIFO_DEPTH = 4.

1. Reset, then read addresses 0 and 1 -> DATA reads 32'hFFFF_FFFF; STATUS reads 32'h0000_0100; irq = 0.
2. Hold keyEnable = 1, keyCode = 4'h5 from edge E -> STATUS count = 1 after edge E+5; irq = 1 after E+6; DATA = 32'h0000_0015. Write 1 to addr 0 -> count = 0 and irq falls on the next edge.
3. Toggle keyEnable every 3 cycles for 40 cycles, then settle at 0 -> no event is ever pushed and count stays 0.
4. Press 4'h5, release, press 4'hA, release (each held 10 cycles) -> FIFO holds 0x15, 0x05, 0x1A, 0x0A in order; full = 1. A fifth transition sets ovf = 1 with count = 4.
5. With the FIFO full, pop in the exact cycle an event is generated -> count stays 4, ovf stays 0, and the new event is at the tail.
6. Write STATUS = 3 in the same cycle an event is generated -> count = 0, empty = 1, ovf = 0; irq falls on the next edge.
